// File: rtl/rgu_pkg.sv
// Shared types and constants for the RGU reset-release sequencer.
package rgu_pkg;

    localparam int RGU_TMR_W      = 16;
    localparam int RGU_DEB_CYCLES = 5;

    typedef enum logic [2:0] {
        SEQ_RESET_HOLD = 3'd0,
        SEQ_WAIT0      = 3'd1,
        SEQ_WAIT1      = 3'd2,
        SEQ_RUN        = 3'd3,
        SEQ_WARM_HOLD  = 3'd4
    } rgu_seq_state_e;

    // Bit positions inside RGU_RST_STATUS; watchdog causes occupy RST_WDT0 upward.
    localparam int RST_POR    = 0;
    localparam int RST_EXT    = 1;
    localparam int RST_SB_WDT = 2;
    localparam int RST_SW     = 3;
    localparam int RST_WDT0   = 4;

endpackage

// File: rtl/rgu_sync_deb.sv
// Input synchroniser for an active-low asynchronous reset request, with an
// optional low-level debounce counter. Output req is active-high.
module rgu_sync_deb #(
    parameter int STAGES     = 2,
    parameter bit DEB_EN     = 1'b0,
    parameter int DEB_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_n,
    output logic req
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              sync_low;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_n};
    end

    // Flops reset to 1 so a power-on reset never looks like a pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_low = ~sync_q[STAGES-1];

    generate
        if (DEB_EN) begin : g_deb
            localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
            localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Count saturates one short of DEB_CYCLES so req fires on the last low sample.
            always_comb begin
                cnt_d = '0;
                if (sync_low) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign req = sync_low & (cnt_q == CNT_MAX);
        end else begin : g_nodeb
            assign req = sync_low;
        end
    endgenerate

endmodule

// File: rtl/rgu_rst_seq.sv
// RGU reset-release sequencer: merges reset sources and walks the sandbox
// (stage 0) then system (stage 1) release with programmable dwell times.
module rgu_rst_seq
    import rgu_pkg::*;
#(
    parameter int TMR_W       = RGU_TMR_W,
    parameter int DEB_CYCLES  = RGU_DEB_CYCLES,
    parameter int SYNC_STAGES = 2,
    parameter int N_WDT       = 4
) (
    input  logic             clk,
    input  logic             sys_pwrgd,
    input  logic             sys_reset_n,
    input  logic             sb_wdt_rst_n,
    input  logic [N_WDT-1:0] wdt_rst_n,
    input  logic             sw_glb_rst,
    input  logic [TMR_W-1:0] timer0_cfg,
    input  logic [TMR_W-1:0] timer1_cfg,
    input  logic [7:0]       status_w1c,
    output logic             stage0_done,
    output logic             stage1_done,
    output logic [7:0]       rst_status,
    output logic [2:0]       seq_state
);

    localparam logic [2:0] ST_RESET_HOLD = SEQ_RESET_HOLD;
    localparam logic [2:0] ST_WAIT0      = SEQ_WAIT0;
    localparam logic [2:0] ST_WAIT1      = SEQ_WAIT1;
    localparam logic [2:0] ST_RUN        = SEQ_RUN;
    localparam logic [2:0] ST_WARM_HOLD  = SEQ_WARM_HOLD;

    logic             ext_req;
    logic             sb_req;
    logic [N_WDT-1:0] wdt_req;
    logic [3:0]       wdt_cause;
    logic             full_req;
    logic             warm_req;

    logic [2:0]       state_q,  state_d;
    logic [TMR_W-1:0] cnt_q,    cnt_d;
    logic [TMR_W-1:0] dwell_q,  dwell_d;
    logic             stage0_q, stage0_d;
    logic             stage1_q, stage1_d;
    logic [7:0]       status_q, status_d;
    logic [7:0]       status_set;
    logic             expired;

    function automatic logic [TMR_W-1:0] load_dwell(input logic [TMR_W-1:0] cfg);
        return (cfg == '0) ? TMR_W'(1) : cfg;
    endfunction

    rgu_sync_deb #(
        .STAGES     (SYNC_STAGES),
        .DEB_EN     (1'b1),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_ext_sync (
        .clk     (clk),
        .rst_n   (sys_pwrgd),
        .async_n (sys_reset_n),
        .req     (ext_req)
    );

    rgu_sync_deb #(
        .STAGES     (SYNC_STAGES),
        .DEB_EN     (1'b0),
        .DEB_CYCLES (1)
    ) u_sb_sync (
        .clk     (clk),
        .rst_n   (sys_pwrgd),
        .async_n (sb_wdt_rst_n),
        .req     (sb_req)
    );

    generate
        for (genvar i = 0; i < N_WDT; i++) begin : g_wdt
            rgu_sync_deb #(
                .STAGES     (SYNC_STAGES),
                .DEB_EN     (1'b0),
                .DEB_CYCLES (1)
            ) u_wdt_sync (
                .clk     (clk),
                .rst_n   (sys_pwrgd),
                .async_n (wdt_rst_n[i]),
                .req     (wdt_req[i])
            );
        end
        // Only four watchdog cause bits exist in the status register.
        for (genvar j = 0; j < 4; j++) begin : g_cause
            if (j < N_WDT) begin : g_used
                assign wdt_cause[j] = wdt_req[j];
            end else begin : g_unused
                assign wdt_cause[j] = 1'b0;
            end
        end
    endgenerate

    assign full_req = ext_req | sb_req | sw_glb_rst;
    assign warm_req = |wdt_req;
    assign expired  = (cnt_q == dwell_q - TMR_W'(1));

    // Full reset outranks everything; within WAIT1 a warm request outranks expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + TMR_W'(1);
        dwell_d = dwell_q;
        if (full_req) begin
            state_d = ST_RESET_HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RESET_HOLD: begin
                    cnt_d = '0;
                    if (!warm_req) begin
                        state_d = ST_WAIT0;
                        dwell_d = load_dwell(timer0_cfg);
                    end
                end
                ST_WAIT0: begin
                    if (expired) begin
                        state_d = ST_WAIT1;
                        dwell_d = load_dwell(timer1_cfg);
                        cnt_d   = '0;
                    end
                end
                ST_WAIT1: begin
                    if (warm_req) begin
                        state_d = ST_WARM_HOLD;
                        cnt_d   = '0;
                    end else if (expired) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                    if (warm_req) begin
                        state_d = ST_WARM_HOLD;
                    end
                end
                ST_WARM_HOLD: begin
                    cnt_d = '0;
                    if (!warm_req) begin
                        state_d = ST_WAIT1;
                        dwell_d = load_dwell(timer1_cfg);
                    end
                end
                default: begin
                    state_d = ST_RESET_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stage0_d = (state_d == ST_WAIT1) || (state_d == ST_RUN) || (state_d == ST_WARM_HOLD);
        stage1_d = (state_d == ST_RUN);
    end

    // A fresh cause set beats a simultaneous write-1-to-clear of the same bit.
    always_comb begin
        status_set = '0;
        if (state_q != ST_RESET_HOLD) begin
            status_set[RST_EXT]    = ext_req;
            status_set[RST_SB_WDT] = sb_req;
            status_set[RST_SW]     = sw_glb_rst;
        end
        if (state_q != ST_WARM_HOLD) begin
            status_set[RST_WDT0 +: 4] = wdt_cause;
        end
        status_d = (status_q & ~status_w1c) | status_set;
    end

    always_ff @(posedge clk or negedge sys_pwrgd) begin
        if (!sys_pwrgd) begin
            state_q  <= ST_RESET_HOLD;
            cnt_q    <= '0;
            dwell_q  <= TMR_W'(1);
            stage0_q <= 1'b0;
            stage1_q <= 1'b0;
            status_q <= 8'h01;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            stage0_q <= stage0_d;
            stage1_q <= stage1_d;
            status_q <= status_d;
        end
    end

    assign stage0_done = stage0_q;
    assign stage1_done = stage1_q;
    assign rst_status  = status_q;
    assign seq_state   = state_q;

endmodule
